mr_alu_wb: RTL
==============

// Module: mr_alu_wb
// PURPOSE
// - Execute-to-writeback stage directly downstream of the registered-output ALU.
// - Pairs each issued ALU op's destination register tag with the ALU result one cycle
//   later, and buffers completed results in an in-order FIFO.
// - Presents results to the register-file writeback port over a valid/ready handshake.
// - Provides a forwarding tap for the in-flight result and back-pressures issue.
// PARAMETERS
// - XLEN   `XLEN (config.svi)  datapath width
// - DEPTH  3                   result FIFO entries (>=1). DEPTH>=3 sustains 1 op/cycle with wb_ready=1.
// PORTS
// - clk          in   1     clock; all state updates on posedge clk
// - rst          in   1     synchronous reset, active-high
// - issue_valid  in   1     ALU op (arg1/arg2/op) presented to the ALU this cycle
// - issue_rd     in   5     destination register of that op
// - issue_ready  out  1     stage can accept an op this cycle
// - alu_dest     in   XLEN  ALU registered result; valid the cycle after issue
// - fwd_valid    out  1     in-flight result available on fwd_* this cycle
// - fwd_rd       out  5     register of in-flight result
// - fwd_data     out  XLEN  in-flight result (combinational copy of alu_dest)
// - wb_valid     out  1     FIFO head valid
// - wb_rd        out  5     FIFO head register
// - wb_data      out  XLEN  FIFO head data
// - wb_ready     in   1     writeback consumes head when wb_valid && wb_ready
// BEHAVIOUR
// - Accept: issue fires when issue_valid && issue_ready (cycle N).
//   - Fire with issue_rd!=0: pend_v<=1, pend_rd<=issue_rd.
//   - Fire with issue_rd==0: accepted, result discarded; pend_v<=0.
//   - No fire: pend_v<=0.
// - Capture: in cycle N+1, if pend_v, {pend_rd, alu_dest} is pushed at the FIFO tail
//   at posedge ending N+1. It is visible on wb_* from N+2 when the FIFO was empty.
//   Minimum issue->wb_valid latency is 2 cycles.
// - Forward: fwd_valid=pend_v, fwd_rd=pend_rd, fwd_data=alu_dest (all combinational).
//   - When pend_v=0: fwd_rd=0 and fwd_data=0.
// - Credit rule: issue_ready = !rst && (count + pend_v) < DEPTH.
//   - Depends on state only, with no combinational path from wb_ready or issue_valid.
//   - This guarantees a push never meets a full FIFO.
// - Pop: when wb_valid && wb_ready, the head advances at posedge.
//   - Simultaneous push and pop: count unchanged, order preserved, no loss or duplication.
// - Hold: while wb_valid && !wb_ready, wb_rd and wb_data stay stable.
// - Empty FIFO: wb_valid=0, wb_rd=0, wb_data=0.
// - Order: strictly in issue order. Pointers wrap modulo DEPTH (non-power-of-2 allowed).
// - Reset (and reset mid-operation): at the posedge with rst=1:
//   - count, read and write pointers, pend_v, pend_rd cleared.
//   - All in-flight and buffered results discarded.
//   - Outputs after that edge: wb_valid=0, wb_rd=0, wb_data=0, fwd_valid=0.
//   - issue_ready=0 while rst=1, and 1 in the first cycle after rst falls.
// - Assertions:
//   - push while count==DEPTH is illegal.
//   - wb_valid must equal (count!=0).
// TESTING
// - Single op: reset; issue rd=5 at N; alu_dest=0x1234 at N+1
//   -> fwd_valid=1, fwd_rd=5, fwd_data=0x1234 at N+1; wb_valid=1, wb_rd=5, wb_data=0x1234 at N+2.
// - x0 drop: issue rd=0, alu_dest=0xFFFF_FFFF
//   -> fwd_valid=0 and wb_valid never rises; issue_ready stays 1.
// - Back-pressure: wb_ready=0, issue rd=1,2,3 on consecutive cycles with data 0x11,0x22,0x33
//   -> issue_ready=0 once count+pend_v=3; wb holds rd=1/0x11 stable.
//   - Then raise wb_ready -> 1,2,3 drain in order, one per cycle.
// - Throughput: wb_ready=1, issue every cycle for 10 ops (rd=1..10, data=rd*0x10)
//   -> issue_ready never drops; wb delivers 1..10 on consecutive cycles starting at 2 cycles latency.
// - Wrap-around: 7 ops with random wb_ready stalls
//   -> pointers wrap twice; the output sequence matches issue order exactly.
// - Reset mid-flight: FIFO holding 2 entries plus pend_v=1, assert rst one cycle
//   -> wb_valid=0 and fwd_valid=0 next cycle; no stale entry ever appears afterwards.

Source files
------------

// File: rtl/mr_alu_wb_if.sv
// Issue, forwarding and writeback signals between the execute-to-writeback stage
// and its neighbours. Master drives issue and consumes writeback; slave is the stage.
interface mr_alu_wb_if #(
  parameter int unsigned XLEN = 32
);
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [XLEN-1:0] alu_dest;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;

  modport master (
    output issue_valid, issue_rd, alu_dest, wb_ready,
    input  issue_ready, fwd_valid, fwd_rd, fwd_data, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  issue_valid, issue_rd, alu_dest, wb_ready,
    output issue_ready, fwd_valid, fwd_rd, fwd_data, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/mr_alu_wb.sv
// Execute-to-writeback stage: pairs issued rd tags with the registered ALU result one
// cycle later, queues them in an in-order FIFO and drives the writeback handshake.
module mr_alu_wb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 3
) (
  input logic        clk,
  input logic        rst,
  mr_alu_wb_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;

  logic            pend_v_q, pend_v_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic [CntW-1:0] count_q, count_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  ptr_t            wr_ptr_q, wr_ptr_d;
  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic            fire, push, pop, wb_valid;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Credit counts the pending op too, so a capture can never land on a full FIFO.
  assign bus.issue_ready = !rst && ((32'(count_q) + 32'(pend_v_q)) < DEPTH);

  assign fire     = bus.issue_valid && bus.issue_ready;
  assign push     = pend_v_q;
  assign wb_valid = (count_q != '0);
  assign pop      = wb_valid && bus.wb_ready;

  always_comb begin
    pend_v_d  = fire && (bus.issue_rd != 5'd0);
    pend_rd_d = pend_v_d ? bus.issue_rd : 5'd0;
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q  <= 1'b0;
      pend_rd_q <= 5'd0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_rd_q <= pend_rd_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Storage needs no reset; outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= pend_rd_q;
      data_mem[wr_ptr_q] <= bus.alu_dest;
    end
  end

  assign bus.wb_valid  = wb_valid;
  assign bus.wb_rd     = wb_valid ? rd_mem[rd_ptr_q] : 5'd0;
  assign bus.wb_data   = wb_valid ? data_mem[rd_ptr_q] : '0;

  assign bus.fwd_valid = pend_v_q;
  assign bus.fwd_rd    = pend_v_q ? pend_rd_q : 5'd0;
  assign bus.fwd_data  = pend_v_q ? bus.alu_dest : '0;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CntW'(DEPTH))));
  a_wb_valid_count: assert property (@(posedge clk) disable iff (rst)
    bus.wb_valid == (count_q != '0));

endmodule
